vector_checker: RTL
===================

VECTOR_CHECKER -- requirements
Module: vector_checker

Interface
REQ-001 SHALL have parameter DW, default 1, operand width of a and b.
REQ-002 SHALL have parameter YW, default 1, DUT result width.
REQ-003 SHALL have parameter DEPTH, default 16, vector memory entries (power of 2, >= 2).
REQ-004 SHALL have parameter LAT, default 1, DUT latency in cycles (1..15).
REQ-005 SHALL have ports, clock and reset first:
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  vector memory write strobe
- wr_addr  in  clog2(DEPTH)  write index
- wr_a  in  DW  stimulus a
- wr_b  in  DW  stimulus b
- wr_y  in  YW  expected result
- num  in  clog2(DEPTH)+1  vector count, sampled at start (0..DEPTH)
- start  in  1  run request, single-cycle pulse
- a  out  DW  operand to DUT
- b  out  DW  operand to DUT
- y  in  YW  DUT result
- busy  out  1  run in progress
- done  out  1  run finished, sticky until next start
- pass  out  1  valid when done; 1 = all vectors matched
- fail_step  out  clog2(DEPTH)  index of first mismatch; valid when done && !pass

Function
REQ-006 SHALL write {wr_a, wr_b, wr_y} to entry wr_addr on any cycle with wr_en=1; writes while busy=1 SHALL be ignored.
REQ-007 SHALL implement FSM states IDLE, DRIVE, WAIT, CHECK, DONE.
REQ-008 IDLE/DONE + start=1 -> DRIVE; SHALL latch num, clear step to 0, clear done and pass. start SHALL be ignored in DRIVE, WAIT and CHECK.
REQ-009 start with latched num=0 -> DONE next cycle with pass=1.
REQ-010 DRIVE SHALL register a/b from entry[step] (visible the following cycle), load wait counter with LAT-1, and go to WAIT.
REQ-011 WAIT SHALL decrement the counter and go to CHECK when it reaches 0, so y is sampled exactly LAT cycles after a/b change.
REQ-012 CHECK: y != expected -> DONE, pass=0, fail_step=step (first mismatch only, run aborts).
REQ-013 CHECK: match and step == num-1 -> DONE, pass=1; otherwise step+1 -> DRIVE.
REQ-014 a and b SHALL hold the last driven values in WAIT, CHECK and DONE.
REQ-015 busy SHALL be 1 exactly in DRIVE, WAIT and CHECK.
REQ-016 A run of N matching vectors SHALL take N*(LAT+2) cycles from start to done.
REQ-017 Comparison SHALL be an exact YW-bit equality; no X-masking.

Reset
REQ-018 reset=1 SHALL force state IDLE and set a, b, step, wait counter, fail_step to 0, and busy, done, pass to 0, on the next rising edge.
REQ-019 reset asserted mid-run SHALL abort the run with no done pulse; memory contents SHALL be preserved.
REQ-020 Outputs SHALL be registered; no combinational path from y to any output.

Structure
REQ-021 State enum and LAT counter width constant SHALL live in shared package checker_pkg.
REQ-022 Vector storage SHALL be sub-module vec_mem (1 sync write, 1 async read port, inferable as LUTRAM); FSM and compare in vector_checker.

Verification
REQ-023 DW=1, YW=1, LAT=1, DUT = registered equality; load (0,0,1),(1,0,0),(0,1,0),(1,1,1), num=4, start -> done=1, pass=1 after 12 cycles.
REQ-024 Same setup, entry 2 expected corrupted to 1 -> done=1, pass=0, fail_step=2, a/b frozen at (0,1).
REQ-025 num=0, start -> done=1, pass=1, busy=0 one cycle later; a/b unchanged.
REQ-026 LAT=3 DUT (3-stage pipelined eq), 4 good vectors -> pass=1 after 20 cycles; y sampled exactly 3 cycles after each a/b change.
REQ-027 reset pulsed during WAIT of vector 1 -> IDLE, busy=0, done=0; restart without reload -> pass=1.
REQ-028 wr_en and start pulsed while busy -> memory unchanged, run unaffected, result identical to REQ-023.

Source files
------------

// File: rtl/checker_pkg.sv
// Shared types and constants for the vector checker: FSM state encoding,
// the width of the latency wait counter, and a busy-state decoder.
package checker_pkg;

  // Run sequencer states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRIVE = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Latency counter width; holds LAT-1 for LAT in 1..15
  localparam int CNT_W = 4;

  // A run is in progress while the sequencer is driving, waiting or checking
  function automatic logic is_busy(input state_t s);
    return (s == DRIVE) || (s == WAIT) || (s == CHECK);
  endfunction

endpackage

// File: rtl/vec_mem.sv
// Vector storage: one synchronous write port and one asynchronous read port,
// shaped so synthesis maps it onto distributed (LUT) RAM. Contents are not
// reset so that loaded vectors survive a reset of the sequencer.
module vec_mem #(
  parameter int W     = 3,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Store one packed vector per write strobe
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Asynchronous read of the entry selected by the current step
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/vector_checker.sv
// Self-contained vector checker: plays stored (a, b) stimulus into an external
// DUT, waits LAT cycles, and compares the DUT result y against the stored
// expected value. The first mismatch aborts the run and records its index.
// Every output is registered, so y never reaches an output combinationally.
module vector_checker
  import checker_pkg::*;
#(
  parameter int DW    = 1,
  parameter int YW    = 1,
  parameter int DEPTH = 16,
  parameter int LAT   = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [DW-1:0]              wr_a,
  input  logic [DW-1:0]              wr_b,
  input  logic [YW-1:0]              wr_y,
  input  logic [$clog2(DEPTH):0]     num,
  input  logic                       start,
  output logic [DW-1:0]              a,
  output logic [DW-1:0]              b,
  input  logic [YW-1:0]              y,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [$clog2(DEPTH)-1:0]   fail_step
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int EW = 2 * DW + YW;

  // Wait counter reload value: WAIT lasts exactly LAT cycles
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT - 1);

  // Sequencer state and registered outputs
  state_t           state_q, state_d;
  logic [AW-1:0]    step_q, step_d;
  logic [NW-1:0]    num_q, num_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    a_q, a_d;
  logic [DW-1:0]    b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [AW-1:0]    fail_step_q, fail_step_d;

  // Memory interface
  logic             mem_we;
  logic [EW-1:0]    mem_wdata;
  logic [EW-1:0]    mem_rdata;
  logic [DW-1:0]    entry_a;
  logic [DW-1:0]    entry_b;
  logic [YW-1:0]    entry_y;
  logic             last_step;

  // Loads are locked out while a run is reading the memory
  assign mem_we    = wr_en && !is_busy(state_q);
  assign mem_wdata = {wr_a, wr_b, wr_y};

  vec_mem #(
    .W     (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_vec_mem (
    .clock   (clock),
    .we_i    (mem_we),
    .waddr_i (wr_addr),
    .wdata_i (mem_wdata),
    .raddr_i (step_q),
    .rdata_o (mem_rdata)
  );

  // Unpack the current entry; layout is {a, b, y} from MSB down
  assign entry_a   = mem_rdata[EW-1 -: DW];
  assign entry_b   = mem_rdata[YW +: DW];
  assign entry_y   = mem_rdata[YW-1:0];
  assign last_step = ({1'b0, step_q} == (num_q - NW'(1)));

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      step_q      <= '0;
      num_q       <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_step_q <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      num_q       <= num_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_step_q <= fail_step_d;
    end
  end

  // Next-state logic: drive, wait out the DUT latency, compare, advance
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    num_d       = num_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    pass_d      = pass_q;
    fail_step_d = fail_step_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          num_d       = num;
          step_d      = '0;
          fail_step_d = '0;
          pass_d      = 1'b0;
          if (num == '0) begin
            // An empty run trivially passes without touching a/b
            state_d = DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = DRIVE;
          end
        end
      end

      DRIVE: begin
        a_d     = entry_a;
        b_d     = entry_b;
        cnt_d   = LAT_M1;
        state_d = WAIT;
      end

      WAIT: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      CHECK: begin
        if (y != entry_y) begin
          state_d     = DONE;
          pass_d      = 1'b0;
          fail_step_d = step_q;
        end else if (last_step) begin
          state_d = DONE;
          pass_d  = 1'b1;
        end else begin
          step_d  = step_q + AW'(1);
          state_d = DRIVE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags follow the state being entered so they line up with it
    busy_d = is_busy(state_d);
    done_d = (state_d == DONE);
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_step = fail_step_q;

endmodule
